delay_ctrl: RTL

//  Runtime-programmable delay line: controller plus circular-buffer RAM.

---
 rtl/delay_pkg.sv | 25 ++
 rtl/delay_ram.sv | 24 ++
 rtl/delay_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/delay_pkg.sv
// Shared types and helpers for the programmable delay line.
package delay_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Ceiling log2, usable in constant expressions.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) res = res + 1;
      return res;
   endfunction

   // Map a requested delay onto the legal range 1..max_d.
   function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned max_d);
      if (req == 0) return 1;
      if (req > max_d) return max_d;
      return req;
   endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module delay_ram
   import delay_pkg::*;
#(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [clog2(DEPTH)-1:0]  waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [clog2(DEPTH)-1:0]  raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read returns the old contents when raddr equals waddr.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/delay_ctrl.sv
// Runtime-programmable delay line: FSM, pointers and output stage around delay_ram.
module delay_ctrl
   import delay_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned MAX_DELAY     = 16,
   parameter int unsigned DEFAULT_DELAY = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [clog2(MAX_DELAY):0]    cfg_delay,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [DATA_WIDTH-1:0]        din,
   input  logic                         din_valid,
   output logic [DATA_WIDTH-1:0]        dout,
   output logic                         dvalid,
   output logic                         busy
);

   localparam int unsigned AW  = clog2(MAX_DELAY);
   localparam int unsigned DLW = AW + 1;
   localparam int unsigned EW  = DATA_WIDTH + 1;

   if (MAX_DELAY < 2 || (MAX_DELAY & (MAX_DELAY - 1)) != 0) begin : g_bad_max_delay
      $error("delay_ctrl: MAX_DELAY must be a power of 2 and >= 2");
   end
   if (DEFAULT_DELAY < 1 || DEFAULT_DELAY > MAX_DELAY) begin : g_bad_default_delay
      $error("delay_ctrl: DEFAULT_DELAY must be within 1..MAX_DELAY");
   end

   state_t          state, next_state;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [DLW-1:0]  fill_cnt, delay_q;
   logic [EW-1:0]   din_q, ram_rdata, tap;
   logic            accept, out_en;

   delay_ram #(.WIDTH(EW), .DEPTH(MAX_DELAY)) u_ram (
      .clk   (clk),
      .we    (1'b1),
      .waddr (wr_ptr),
      .wdata ({din_valid, din}),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   // Next state; output is enabled exactly on the edges that lead into RUN.
   always_comb begin
      next_state = state;
      accept     = cfg_valid & cfg_ready;
      case (state)
         FILL: begin
            if (accept)                               next_state = FLUSH;
            else if (fill_cnt == delay_q - DLW'(1))   next_state = RUN;
         end
         RUN:     if (accept) next_state = FLUSH;
         FLUSH:   next_state = FILL;
         default: next_state = FILL;
      endcase
      out_en = (next_state == RUN);
   end

   // RAM read is issued one edge ahead of the output register, so it looks D-2
   // entries back; delays 1 and 2 are too short for that and use direct taps.
   always_comb begin
      rd_ptr = wr_ptr - AW'(delay_q - DLW'(2));
      if (delay_q == DLW'(1))      tap = {din_valid, din};
      else if (delay_q == DLW'(2)) tap = din_q;
      else                         tap = ram_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL;
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         delay_q   <= DLW'(DEFAULT_DELAY);
         din_q     <= '0;
         dout      <= '0;
         dvalid    <= 1'b0;
         cfg_ready <= 1'b1;
         busy      <= 1'b1;
      end else begin
         state  <= next_state;
         wr_ptr <= wr_ptr + AW'(1);
         din_q  <= {din_valid, din};
         if (accept) delay_q <= DLW'(clamp_delay(32'(cfg_delay), MAX_DELAY));
         if (state == FILL)       fill_cnt <= fill_cnt + DLW'(1);
         else if (state == FLUSH) fill_cnt <= '0;
         dout      <= out_en ? tap[DATA_WIDTH-1:0] : '0;
         dvalid    <= out_en & tap[DATA_WIDTH];
         cfg_ready <= (next_state != FLUSH);
         busy      <= (next_state != RUN);
      end
   end

endmodule
